// File: rtl/irq_pending_dispatch.sv
// Request edge capture, masking and lowest-index dispatch over a valid/ready handshake.
// Rising edges on irq_in set pending bits; the lowest pending unmasked line is offered as pos.
module irq_pending_dispatch #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] irq_in,
  input  logic [N-1:0] irq_mask,
  input  logic         pos_ready,
  output logic         pos_valid,
  output logic [W-1:0] pos,
  output logic [N-1:0] pending,
  output logic         lost_irq
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t       state;
  logic [N-1:0] irq_d;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [N-1:0] pend_nxt;
  logic         hs;
  logic         lost_nxt;
  logic         cand_any;
  logic [W-1:0] low_idx;

  always_comb begin
    rise = irq_in & ~irq_d;
    hs   = pos_valid & pos_ready;
    clr  = '0;
    if (hs) clr[pos] = 1'b1;
    // A rise on the bit being served re-pends it rather than counting as lost.
    pend_nxt = rise | (pending & ~clr);
    lost_nxt = |(rise & pending & ~clr);
    cand     = pending & ~irq_mask;
    cand_any = |cand;
    low_idx  = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (cand[i-1]) low_idx = W'(i - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d    <= '0;
      pending  <= '0;
      lost_irq <= 1'b0;
    end else begin
      irq_d    <= irq_in;
      pending  <= pend_nxt;
      lost_irq <= lost_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pos       <= '0;
      pos_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_any) begin
            pos       <= low_idx;
            pos_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (pos_ready) begin
            pos_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          pos_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_dispatch.sv
// Scoreboard bench for irq_pending_dispatch: a behavioural model predicts offers,
// pending state and lost pulses; a negedge monitor compares against the DUT.
module tb_irq_pending_dispatch;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic [N-1:0] irq_mask = '0;
  logic         pos_ready = 1'b0;
  logic         pos_valid;
  logic [W-1:0] pos;
  logic [N-1:0] pending;
  logic         lost_irq;

  irq_pending_dispatch #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_mask(irq_mask),
    .pos_ready(pos_ready), .pos_valid(pos_valid), .pos(pos),
    .pending(pending), .lost_irq(lost_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int lost_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a set of pending lines, the previous request levels, and the current offer.
  bit     m_prev[N];
  bit     m_pend[N];
  bit     m_off;
  int     m_pos;
  bit     m_lost;
  int     exp_q[$];

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_prev[i] = 0; m_pend[i] = 0; end
      m_off = 0; m_pos = 0; m_lost = 0;
      exp_q.delete();
    end else begin
      bit served;
      int pick;
      served = m_off && pos_ready;
      pick = -1;
      if (!m_off)
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && !irq_mask[i]) pick = i;
      m_lost = 0;
      for (int i = 0; i < N; i++) begin
        bit r;
        r = irq_in[i] && !m_prev[i];
        if (r && m_pend[i] && !(served && i == m_pos)) m_lost = 1;
        if (r) m_pend[i] = 1;
        else if (served && i == m_pos) m_pend[i] = 0;
        m_prev[i] = irq_in[i];
      end
      if (served) m_off = 0;
      else if (pick >= 0) begin
        m_off = 1; m_pos = pick;
        exp_q.push_back(pick);
      end
    end
  end

  // Monitor: every cycle state comparison, plus one scoreboard pop per new offer.
  bit prev_v = 0;
  always @(negedge clk) begin
    if (!rst_n) prev_v = 0;
    else begin
      chk("pos_valid", pos_valid, m_off);
      chk("pending", pending, pend_vec());
      chk("lost_irq", lost_irq, m_lost);
      if (lost_irq) lost_seen++;
      if (m_off) chk("pos_held", pos, m_pos);
      if (pos_valid && !prev_v) begin
        if (exp_q.size() == 0) chk("offer_unexpected", pos, 32'hFFFF);
        else chk("offer_pos", pos, exp_q.pop_front());
      end
      prev_v = pos_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lost_start;
    step(2);
    rst_n = 1'b1;
    chk("rst_pending", pending, 0);
    chk("rst_valid", pos_valid, 0);
    step(2);

    // single rise on bit 5
    irq_in = 8'h20; pos_ready = 1'b1;
    step(1);
    chk("t0_pending", pending, 8'h20);
    chk("t0_valid", pos_valid, 0);
    step(1);
    chk("t1_valid", pos_valid, 1);
    chk("t1_pos", pos, 5);
    step(1);
    chk("t2_valid", pos_valid, 0);
    chk("t2_pending", pending, 0);
    irq_in = 8'h00; step(3);

    // simultaneous rises, lowest first
    lost_start = lost_seen;
    irq_in = 8'b1001_0100; step(10);
    chk("multi_pending", pending, 0);
    chk("multi_nolost", lost_seen - lost_start, 0);
    irq_in = 8'h00; step(2);

    // masked line retained, dispatched when unmasked
    irq_mask = 8'h01; irq_in = 8'h09; step(6);
    chk("mask_pending", pending, 8'h01);
    irq_mask = 8'h00; step(4);
    irq_in = 8'h00; step(2);

    // held offer while another line rises
    pos_ready = 1'b0; irq_in = 8'h40; step(3);
    irq_in = 8'h42; step(10);
    chk("hold_pos", pos, 6);
    pos_ready = 1'b1; step(6);
    irq_in = 8'h00; step(2);

    // lost edge on pending bit 2, then re-rise in handshake cycle
    pos_ready = 1'b0; irq_in = 8'h04; step(3);
    lost_start = lost_seen;
    irq_in = 8'h00; step(1);
    irq_in = 8'h04; step(4);
    chk("lost_once", lost_seen - lost_start, 1);
    irq_in = 8'h00; step(1);
    lost_start = lost_seen;
    irq_in = 8'h04; pos_ready = 1'b1; step(1);
    chk("rerise_pend", pending, 8'h04);
    pos_ready = 1'b0; step(2);
    chk("rerise_pos", pos, 2);
    chk("rerise_nolost", lost_seen - lost_start, 0);
    pos_ready = 1'b1; step(3);
    irq_in = 8'h00; step(2);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      irq_in = $urandom_range(0, 3) == 0 ? N'($urandom) : irq_in;
      if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom) & N'($urandom);
      pos_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    irq_mask = 8'h00; irq_in = 8'h00; pos_ready = 1'b1; step(20);

    // reset during an offer with all lines pending
    pos_ready = 1'b0; irq_in = 8'hFF; step(4);
    chk("pre_rst_pending", pending, 8'hFF);
    @(negedge clk); #2;
    rst_n = 1'b0; irq_in = 8'h01;
    #1;
    chk("arst_valid", pos_valid, 0);
    chk("arst_pending", pending, 0);
    chk("arst_pos", pos, 0);
    chk("arst_lost", lost_irq, 0);
    step(2);
    rst_n = 1'b1;
    pos_ready = 1'b1;
    step(1);
    chk("rel_pending", pending, 8'h01);
    step(1);
    chk("rel_valid", pos_valid, 1);
    chk("rel_pos", pos, 0);
    step(4);
    chk("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
